// File: rtl/dat_phys_wrapper.sv
// Serial engine for one SD DAT line: start/data/CRC16/end framing on transmit,
// block or CRC-status token capture on receive.
module dat_phys_wrapper #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CRC_WIDTH  = 16,
  parameter logic [2:0]  TOKEN_OK   = 3'b010
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  reset_wrapper,
  input  logic                  enable_pts_wrapper,
  input  logic                  load_send,
  input  logic                  enable_stp_wrapper,
  input  logic                  waiting_response,
  input  logic [DATA_WIDTH-1:0] dataParallel,
  input  logic                  dat_in,
  output logic                  dat_out,
  output logic                  dat_oe,
  output logic                  transmission_complete,
  output logic                  reception_complete,
  output logic [DATA_WIDTH-1:0] dataRead,
  output logic                  crc_error,
  output logic [2:0]            crc_status
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned TOK_W = 3;

  localparam logic [CRC_WIDTH-1:0] CRC_POLY     = CRC_WIDTH'(16'h1021);
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]     TX_DATA_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     TX_CRC_LAST  = CNT_W'(CRC_WIDTH);
  localparam logic [CNT_W-1:0]     RX_DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]     RX_CRC_LAST  = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CNT_W-1:0]     TK_LAST      = CNT_W'(TOK_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_CRC,
    S_TX_END,
    S_RX_WAIT,
    S_RX_DATA,
    S_RX_CRC,
    S_RX_END,
    S_TK_WAIT,
    S_TK_BITS,
    S_TK_END
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load_armed_q, load_armed_d;
  logic                  dat_out_q, dat_out_d;
  logic                  dat_oe_q, dat_oe_d;
  logic                  tx_done_q, tx_done_d;
  logic                  rx_done_q, rx_done_d;
  logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
  logic                  crc_error_q, crc_error_d;
  logic [2:0]            crc_status_q, crc_status_d;

  // One MSB-first step of the x^16+x^12+x^5+1 LFSR.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic bit_in);
    logic fb;
    fb = crc[CRC_WIDTH-1] ^ bit_in;
    crc_step = {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // Outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    cnt_d        = cnt_q;
    load_armed_d = load_armed_q | ~load_send;
    dat_out_d    = 1'b1;
    dat_oe_d     = 1'b0;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    data_read_d  = data_read_q;
    crc_error_d  = crc_error_q;
    crc_status_d = crc_status_q;

    case (state_q)
      S_IDLE: begin
        if (enable_pts_wrapper && load_send && load_armed_q) begin
          state_d      = S_TX_START;
          shift_d      = dataParallel;
          crc_d        = '0;
          cnt_d        = '0;
          load_armed_d = 1'b0;
          dat_out_d    = 1'b0;
          dat_oe_d     = 1'b1;
        end else if (waiting_response) begin
          state_d = S_TK_WAIT;
        end else if (enable_stp_wrapper) begin
          state_d = S_RX_WAIT;
        end
      end

      S_TX_START: begin
        state_d   = S_TX_DATA;
        dat_oe_d  = 1'b1;
        dat_out_d = shift_q[DATA_WIDTH-1];
        shift_d   = shift_q << 1;
        crc_d     = crc_step(crc_q, shift_q[DATA_WIDTH-1]);
        cnt_d     = CNT_ONE;
      end

      S_TX_DATA: begin
        dat_oe_d = 1'b1;
        if (cnt_q == TX_DATA_LAST) begin
          state_d   = S_TX_CRC;
          dat_out_d = crc_q[CRC_WIDTH-1];
          crc_d     = crc_q << 1;
          cnt_d     = CNT_ONE;
        end else begin
          dat_out_d = shift_q[DATA_WIDTH-1];
          shift_d   = shift_q << 1;
          crc_d     = crc_step(crc_q, shift_q[DATA_WIDTH-1]);
          cnt_d     = cnt_q + CNT_ONE;
        end
      end

      S_TX_CRC: begin
        dat_oe_d = 1'b1;
        if (cnt_q == TX_CRC_LAST) begin
          state_d   = S_TX_END;
          tx_done_d = 1'b1;
        end else begin
          dat_out_d = crc_q[CRC_WIDTH-1];
          crc_d     = crc_q << 1;
          cnt_d     = cnt_q + CNT_ONE;
        end
      end

      S_TX_END: begin
        state_d = S_IDLE;
      end

      // Unbounded wait; the controller owns the read timeout.
      S_RX_WAIT: begin
        if (!enable_stp_wrapper) begin
          state_d = S_IDLE;
        end else if (!dat_in) begin
          state_d = S_RX_DATA;
          crc_d   = '0;
          cnt_d   = '0;
        end
      end

      S_RX_DATA: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], dat_in};
        crc_d   = crc_step(crc_q, dat_in);
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == RX_DATA_LAST) begin
          state_d = S_RX_CRC;
          cnt_d   = '0;
        end
      end

      S_RX_CRC: begin
        rx_crc_d = {rx_crc_q[CRC_WIDTH-2:0], dat_in};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == RX_CRC_LAST) begin
          state_d = S_RX_END;
          cnt_d   = '0;
        end
      end

      S_RX_END: begin
        state_d     = S_IDLE;
        rx_done_d   = 1'b1;
        data_read_d = shift_q;
        crc_error_d = (rx_crc_q != crc_q) || !dat_in;
      end

      S_TK_WAIT: begin
        if (!waiting_response) begin
          state_d = S_IDLE;
        end else if (!dat_in) begin
          state_d = S_TK_BITS;
          cnt_d   = '0;
        end
      end

      S_TK_BITS: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], dat_in};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == TK_LAST) begin
          state_d = S_TK_END;
          cnt_d   = '0;
        end
      end

      S_TK_END: begin
        state_d      = S_IDLE;
        rx_done_d    = 1'b1;
        crc_status_d = shift_q[2:0];
        crc_error_d  = (shift_q[2:0] != TOKEN_OK) || !dat_in;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Controller-driven clear wins over everything, aborting any transfer.
    if (reset_wrapper) begin
      state_d      = S_IDLE;
      shift_d      = '0;
      crc_d        = '0;
      rx_crc_d     = '0;
      cnt_d        = '0;
      load_armed_d = 1'b1;
      dat_out_d    = 1'b1;
      dat_oe_d     = 1'b0;
      tx_done_d    = 1'b0;
      rx_done_d    = 1'b0;
      data_read_d  = '0;
      crc_error_d  = 1'b0;
      crc_status_d = 3'b000;
    end
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      cnt_q        <= '0;
      load_armed_q <= 1'b1;
      dat_out_q    <= 1'b1;
      dat_oe_q     <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      data_read_q  <= '0;
      crc_error_q  <= 1'b0;
      crc_status_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      cnt_q        <= cnt_d;
      load_armed_q <= load_armed_d;
      dat_out_q    <= dat_out_d;
      dat_oe_q     <= dat_oe_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      data_read_q  <= data_read_d;
      crc_error_q  <= crc_error_d;
      crc_status_q <= crc_status_d;
    end
  end

  assign dat_out               = dat_out_q;
  assign dat_oe                = dat_oe_q;
  assign transmission_complete = tx_done_q;
  assign reception_complete    = rx_done_q;
  assign dataRead              = data_read_q;
  assign crc_error             = crc_error_q;
  assign crc_status            = crc_status_q;

endmodule

// File: doc/dat_phys_wrapper.md
Name: dat_phys_wrapper

Overview:
Serial engine for one SD DAT line. It sits directly downstream of dat_phys_controller and consumes its wrapper controls: reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper and waiting_response. On the write path it serialises a 32-bit FIFO word as start bit, data, CRC16 and end bit. On the read path it deserialises a data block, or a CRC status token, from the pad, then returns transmission_complete, reception_complete and dataRead to the controller.

Parameters:
DATA_WIDTH, 32, payload bits per block; also the width of dataParallel and dataRead.
CRC_WIDTH, 16, CRC bits per block. The polynomial is fixed at x^16+x^12+x^5+1.
TOKEN_OK, 3'b010, CRC status value that indicates the card accepted the block.

Ports:
sd_clock  in  1  SD bus clock; all logic is on the rising edge.
reset  in  1  Asynchronous, active-low reset.
reset_wrapper  in  1  Synchronous clear from the controller, active high.
enable_pts_wrapper  in  1  Enables the transmit path.
load_send  in  1  Request to start transmitting the word on dataParallel.
enable_stp_wrapper  in  1  Enables data-block reception.
waiting_response  in  1  Enables CRC status token reception.
dataParallel  in  DATA_WIDTH  Word to transmit, from the FIFO.
dat_in  in  1  Serial input from the pad.
dat_out  out  1  Serial output to the pad.
dat_oe  out  1  Pad drive enable.
transmission_complete  out  1  One-cycle pulse when the end bit has been sent.
reception_complete  out  1  One-cycle pulse when a block or token has been received.
dataRead  out  DATA_WIDTH  Last received payload.
crc_error  out  1  Sticky flag for the last reception.
crc_status  out  3  Last received token status.

Behaviour:
- Reset (reset=0, asynchronous) and reset_wrapper=1 (synchronous) have identical effect:
  - state=IDLE, dat_out=1, dat_oe=0;
  - transmission_complete=0, reception_complete=0;
  - dataRead=0, crc_error=0, crc_status=3'b000;
  - shift register, bit counter and CRC cleared;
  - load_armed=1.
  - reset_wrapper overrides every other input in the same cycle. Asserting it mid-transfer aborts the transfer with no complete pulse.
- States:
  - TX path: IDLE, TX_START, TX_DATA, TX_CRC, TX_END.
  - RX path: RX_WAIT, RX_DATA, RX_CRC, RX_END.
  - Token path: TK_WAIT, TK_BITS, TK_END.
- IDLE priority: (1) enable_pts_wrapper && load_send && load_armed, (2) waiting_response, (3) enable_stp_wrapper.
- load_armed:
  - cleared when a transmission starts;
  - set again in any cycle where load_send=0.
  - One load_send assertion yields exactly one block.
- TX path:
  - At acceptance, latch dataParallel and clear the CRC.
  - TX_START: dat_out=0 for 1 cycle.
  - TX_DATA: DATA_WIDTH cycles, MSB first; the CRC is updated with each bit.
  - TX_CRC: CRC_WIDTH cycles, MSB first.
  - TX_END: dat_out=1 for 1 cycle, with transmission_complete=1 in that cycle.
  - Next state is IDLE.
  - dat_oe=1 from TX_START through TX_END, 0 otherwise. When not driving, dat_out=1.
  - Total latency from the acceptance edge to the pulse is 1+DATA_WIDTH+CRC_WIDTH+1 = 50 cycles.
  - Dropping enable_pts_wrapper mid-transfer does not abort; only reset/reset_wrapper abort.
- RX path:
  - RX_WAIT samples dat_in; the first 0 moves to RX_DATA. The wait is unbounded, because the timeout is owned by the controller.
  - RX_DATA shifts in DATA_WIDTH bits MSB first and updates the CRC.
  - RX_CRC shifts in CRC_WIDTH bits.
  - RX_END samples the end bit. On the following edge:
    - dataRead is updated;
    - crc_error = (received CRC != computed CRC) || (end bit == 0);
    - reception_complete is pulsed for 1 cycle;
    - state returns to IDLE.
  - Leaving RX_WAIT because enable_stp_wrapper=0 returns to IDLE.
- Token path:
  - TK_WAIT waits for a start bit 0.
  - TK_BITS captures 3 bits MSB first.
  - TK_END samples the end bit. On the following edge:
    - crc_status is updated;
    - crc_error = (status != TOKEN_OK) || (end bit == 0);
    - reception_complete is pulsed.
  - dataRead is unchanged.
  - If waiting_response drops while in TK_WAIT, return to IDLE.
- During TX, dat_in is ignored. transmission_complete and reception_complete are never asserted in the same cycle.
- CRC: CRC16-CCITT, initial value 0, register shifted MSB first. Only data bits are fed into it.

Test Plan:
1. Reset=0 mid-TX_DATA → next sample: dat_oe=0, dat_out=1, no complete pulse; after release, a new load_send starts a fresh block.
2. Write dataParallel=32'h00000000 with load_send held high → dat_out sequence is 0, 32×0, 16×0, 1; transmission_complete pulses once at cycle 50; no second block until load_send goes low and then high again.
3. Write 32'hA5A50F0F → the 32 bits appear MSB first, followed by CRC bits matching the golden CRC16 model; dat_oe high for exactly 50 cycles.
4. Read with enable_stp_wrapper=1: idle 1s for 7 cycles, then start bit, 32'h12345678, correct CRC, end bit 1 → dataRead=32'h12345678, crc_error=0, one reception_complete pulse. The same stimulus with one CRC bit flipped gives crc_error=1.
5. Token with waiting_response=1: input 0, 010, 1 → crc_status=3'b010, crc_error=0. Input 0, 101, 1 → crc_status=3'b101, crc_error=1.
6. reset_wrapper=1 during RX_CRC → no pulse and dataRead unchanged (0); a following valid block is received correctly.
